// File: rtl/earth_rx_drain.sv
// earth_rx_drain: pulls whole frames out of the Ethernet RX FIFO into a
// downstream user FIFO. Frame length arrives on a separate strobe and is
// captured in a one-deep pending slot. Oversize frames are read out and
// dropped. Every enable starts with a FIFO flush.
module earth_rx_drain #(
  parameter int MAX_LEN   = 1500,
  parameter int FLUSH_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        erx_empty,
  output logic        erx_rd_en,
  input  logic [63:0] erx_dout,
  input  logic        erx_len_valid,
  input  logic [15:0] erx_data_length,
  output logic        erx_fifo_rst,
  input  logic        d_afull,
  output logic        d_wr_en,
  output logic [63:0] d_din,
  output logic        d_last,
  output logic [3:0]  d_last_bytes,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt,
  output logic        len_ovf,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FLUSH      = 3'd1,
    WAIT_EMPTY = 3'd2,
    WAIT_LEN   = 3'd3,
    DRAIN      = 3'd4,
    DISCARD    = 3'd5
  } state_t;

  localparam logic [7:0]  FLUSH_LAST = 8'(FLUSH_CYC - 1);
  localparam logic [15:0] MAX_LEN_W  = 16'(MAX_LEN);

  state_t      state_r;
  logic [7:0]  flush_cnt_r;
  logic        pend_valid_r;
  logic [15:0] pend_len_r;
  logic [13:0] words_left_r;
  logic [3:0]  lastb_r;

  logic        rd_s;
  logic        consume_s;
  logic        slot_ok_s;
  logic        last_rd_s;
  logic [13:0] words_calc_s;
  logic [3:0]  lastb_calc_s;

  // Data is never buffered here: the FIFO output goes straight downstream.
  assign d_din     = erx_dout;
  assign erx_rd_en = rd_s;

  // Read strobe, slot handshake and length decode derived from current state.
  always_comb begin
    rd_s         = 1'b0;
    consume_s    = (state_r == WAIT_LEN) && en && pend_valid_r;
    slot_ok_s    = (state_r != IDLE) && (state_r != FLUSH);
    // Words fit 14 bits even for a 65535-byte length (8192 words).
    words_calc_s = 14'(({1'b0, pend_len_r} + 17'd7) >> 3);
    lastb_calc_s = (pend_len_r[2:0] == 3'd0) ? 4'd8 : {1'b0, pend_len_r[2:0]};
    case (state_r)
      DRAIN:   rd_s = !rst && !erx_empty && !d_afull && (words_left_r != 14'd0);
      DISCARD: rd_s = !rst && !erx_empty && (words_left_r != 14'd0);
      default: rd_s = 1'b0;
    endcase
    last_rd_s = rd_s && (words_left_r == 14'd1);
  end

  // Frame FSM, length slot, downstream write pipeline and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      flush_cnt_r  <= 8'd0;
      pend_valid_r <= 1'b0;
      pend_len_r   <= 16'd0;
      words_left_r <= 14'd0;
      lastb_r      <= 4'd0;
      erx_fifo_rst <= 1'b0;
      d_wr_en      <= 1'b0;
      d_last       <= 1'b0;
      d_last_bytes <= 4'd0;
      frame_done   <= 1'b0;
      frame_cnt    <= 16'd0;
      drop_cnt     <= 16'd0;
      len_ovf      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // The word read in the previous cycle lands downstream now, even if
      // the block is being disabled; it is only marked last when the frame
      // actually completes.
      frame_done   <= 1'b0;
      d_wr_en      <= rd_s && (state_r == DRAIN);
      d_last       <= last_rd_s && (state_r == DRAIN) && en;
      d_last_bytes <= (last_rd_s && (state_r == DRAIN) && en) ? lastb_r : 4'd0;

      // One-deep length slot; a load wins over a same-cycle consume.
      if (!slot_ok_s) begin
        pend_valid_r <= 1'b0;
      end else if (erx_len_valid) begin
        if (pend_valid_r && !consume_s) begin
          len_ovf <= 1'b1;
        end else begin
          pend_valid_r <= 1'b1;
          pend_len_r   <= erx_data_length;
        end
      end else if (consume_s) begin
        pend_valid_r <= 1'b0;
      end else begin
        pend_valid_r <= pend_valid_r;
      end

      if (!en) begin
        state_r      <= IDLE;
        erx_fifo_rst <= 1'b0;
        busy         <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            state_r      <= FLUSH;
            flush_cnt_r  <= 8'd0;
            erx_fifo_rst <= 1'b1;
            len_ovf      <= 1'b0;
            busy         <= 1'b1;
          end
          FLUSH: begin
            if (flush_cnt_r == FLUSH_LAST) begin
              state_r      <= WAIT_EMPTY;
              erx_fifo_rst <= 1'b0;
            end else begin
              flush_cnt_r <= flush_cnt_r + 8'd1;
            end
          end
          WAIT_EMPTY: begin
            if (erx_empty) begin
              state_r <= WAIT_LEN;
              busy    <= 1'b0;
            end else begin
              state_r      <= FLUSH;
              flush_cnt_r  <= 8'd0;
              erx_fifo_rst <= 1'b1;
              len_ovf      <= 1'b0;
            end
          end
          WAIT_LEN: begin
            if (pend_valid_r) begin
              words_left_r <= words_calc_s;
              lastb_r      <= lastb_calc_s;
              if (pend_len_r == 16'd0) begin
                state_r <= WAIT_LEN;
              end else if (pend_len_r > MAX_LEN_W) begin
                state_r <= DISCARD;
                busy    <= 1'b1;
              end else begin
                state_r <= DRAIN;
                busy    <= 1'b1;
              end
            end
          end
          DRAIN: begin
            if (rd_s) begin
              words_left_r <= words_left_r - 14'd1;
              if (last_rd_s) begin
                state_r    <= WAIT_LEN;
                busy       <= 1'b0;
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 16'd1;
              end
            end
          end
          DISCARD: begin
            if (rd_s) begin
              words_left_r <= words_left_r - 14'd1;
              if (last_rd_s) begin
                state_r    <= WAIT_LEN;
                busy       <= 1'b0;
                frame_done <= 1'b1;
                drop_cnt   <= drop_cnt + 16'd1;
              end
            end
          end
          default: begin
            state_r      <= IDLE;
            erx_fifo_rst <= 1'b0;
            busy         <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_earth_rx_drain.sv
// Directed bench for earth_rx_drain: an RX FIFO model feeds the DUT, a
// downstream monitor checks written data against the pushed pattern.
module tb_earth_rx_drain;

  logic        clk;
  logic        rst;
  logic        en;
  logic        erx_empty;
  logic        erx_rd_en;
  logic [63:0] erx_dout;
  logic        erx_len_valid;
  logic [15:0] erx_data_length;
  logic        erx_fifo_rst;
  logic        d_afull;
  logic        d_wr_en;
  logic [63:0] d_din;
  logic        d_last;
  logic [3:0]  d_last_bytes;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic        len_ovf;
  logic        busy;

  earth_rx_drain #(.MAX_LEN(1500), .FLUSH_CYC(4)) dut (
    .clk(clk), .rst(rst), .en(en),
    .erx_empty(erx_empty), .erx_rd_en(erx_rd_en), .erx_dout(erx_dout),
    .erx_len_valid(erx_len_valid), .erx_data_length(erx_data_length),
    .erx_fifo_rst(erx_fifo_rst), .d_afull(d_afull), .d_wr_en(d_wr_en),
    .d_din(d_din), .d_last(d_last), .d_last_bytes(d_last_bytes),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
    .len_ovf(len_ovf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] len;
    logic [15:0] words;
    logic [3:0]  lastb;
    logic        drop;
    logic        done;
  } vec_t;

  vec_t vec [8];

  logic [63:0] q [$];
  logic [63:0] exp_q [$];
  logic [63:0] pat;

  int checks, errors;
  int n_rd, n_wr, n_last, n_done, n_frst, data_err, bad_lb, last_bytes_seen;
  int exp_frames, exp_drops;
  int r0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic clr();
    n_rd = 0; n_wr = 0; n_last = 0; n_done = 0; n_frst = 0;
    data_err = 0; bad_lb = 0; last_bytes_seen = 0;
  endtask

  // One clock: monitor at negedge, then model the FIFO just after posedge.
  task automatic cyc();
    logic rd, frst;
    @(negedge clk);
    rd   = erx_rd_en;
    frst = erx_fifo_rst;
    if (rd) n_rd++;
    if (frst) n_frst++;
    if (frame_done) n_done++;
    if (!d_last && d_last_bytes != 4'd0) bad_lb++;
    if (d_wr_en) begin
      n_wr++;
      if (exp_q.size() == 0) data_err++;
      else if (d_din != exp_q.pop_front()) data_err++;
      if (d_last) begin
        n_last++;
        last_bytes_seen = int'(d_last_bytes);
      end
    end
    @(posedge clk);
    #1;
    if (frst) q.delete();
    if (rd && q.size() > 0) erx_dout = q.pop_front();
    erx_empty = (q.size() == 0);
  endtask

  task automatic push_words(input int n, input logic keep);
    for (int i = 0; i < n; i++) begin
      q.push_back(pat);
      if (keep) exp_q.push_back(pat);
      pat = pat + 64'd1;
    end
    erx_empty = (q.size() == 0);
  endtask

  task automatic strobe(input logic [15:0] len);
    erx_len_valid   = 1'b1;
    erx_data_length = len;
    cyc();
    erx_len_valid   = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit);
    int k;
    k = 0;
    while (n_done < target && k < limit) begin
      cyc();
      k++;
    end
  endtask

  task automatic wait_rd(input int target, input int limit);
    int k;
    k = 0;
    while (n_rd < target && k < limit) begin
      cyc();
      k++;
    end
  endtask

  initial begin
    checks = 0; errors = 0; exp_frames = 0; exp_drops = 0;
    pat = 64'h1000_0000_0000_0000;
    rst = 1'b1; en = 1'b0; erx_empty = 1'b1; erx_dout = 64'd0;
    erx_len_valid = 1'b0; erx_data_length = 16'd0; d_afull = 1'b0;
    clr();
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    // Reset state
    chk("rst_fifo_rst", int'(erx_fifo_rst), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    chk("rst_len_ovf", int'(len_ovf), 0);
    chk("rst_wr_en", int'(d_wr_en), 0);
    chk("rst_rd_en", int'(erx_rd_en), 0);

    // Enable with empty FIFO: four flush cycles then idle in WAIT_LEN
    clr();
    en = 1'b1;
    repeat (12) cyc();
    chk("flush_cycles", n_frst, 4);
    chk("flush_busy", int'(busy), 0);
    chk("flush_reads", n_rd, 0);

    // Table-driven frames
    vec[0] = '{16'd20,   16'd3,   4'd4, 1'b0, 1'b1};
    vec[1] = '{16'd1600, 16'd200, 4'd0, 1'b1, 1'b1};
    vec[2] = '{16'd8,    16'd1,   4'd8, 1'b0, 1'b1};
    vec[3] = '{16'd1,    16'd1,   4'd1, 1'b0, 1'b1};
    vec[4] = '{16'd9,    16'd2,   4'd1, 1'b0, 1'b1};
    vec[5] = '{16'd1500, 16'd188, 4'd4, 1'b0, 1'b1};
    vec[6] = '{16'd1501, 16'd188, 4'd0, 1'b1, 1'b1};
    vec[7] = '{16'd0,    16'd0,   4'd0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      clr();
      push_words(int'(vec[i].words), !vec[i].drop);
      strobe(vec[i].len);
      wait_done(1, vec[i].done ? 600 : 12);
      cyc();
      if (vec[i].done && vec[i].drop) exp_drops++;
      if (vec[i].done && !vec[i].drop) exp_frames++;
      chk($sformatf("v%0d_done", i), n_done, int'(vec[i].done));
      chk($sformatf("v%0d_reads", i), n_rd, int'(vec[i].words));
      chk($sformatf("v%0d_writes", i), n_wr, vec[i].drop ? 0 : int'(vec[i].words));
      chk($sformatf("v%0d_lastb", i), last_bytes_seen, int'(vec[i].lastb));
      chk($sformatf("v%0d_frame_cnt", i), int'(frame_cnt), exp_frames);
      chk($sformatf("v%0d_drop_cnt", i), int'(drop_cnt), exp_drops);
      chk($sformatf("v%0d_data", i), data_err + bad_lb, 0);
    end

    // Length 64 with d_afull held five cycles after the second read
    clr();
    push_words(8, 1'b1);
    strobe(16'd64);
    wait_rd(2, 20);
    d_afull = 1'b1;
    r0 = n_rd;
    repeat (5) cyc();
    chk("afull_paused", n_rd - r0, 0);
    d_afull = 1'b0;
    wait_done(1, 40);
    cyc();
    exp_frames++;
    chk("afull_writes", n_wr, 8);
    chk("afull_lastb", last_bytes_seen, 8);
    chk("afull_data", data_err + int'(exp_q.size()), 0);
    chk("afull_frame_cnt", int'(frame_cnt), exp_frames);

    // Three back-to-back strobes: first consumed, second held, third lost
    clr();
    push_words(102, 1'b1);
    strobe(16'd800);
    strobe(16'd16);
    strobe(16'd24);
    wait_done(2, 400);
    cyc();
    exp_frames += 2;
    chk("triple_ovf", int'(len_ovf), 1);
    chk("triple_done", n_done, 2);
    chk("triple_writes", n_wr, 102);
    chk("triple_lasts", n_last, 2);
    chk("triple_data", data_err + int'(exp_q.size()), 0);
    chk("triple_frame_cnt", int'(frame_cnt), exp_frames);

    // Disable after 3 of 10 words, then re-enable
    clr();
    push_words(10, 1'b1);
    strobe(16'd80);
    wait_rd(3, 20);
    en = 1'b0;
    cyc();
    r0 = n_rd;
    repeat (10) cyc();
    chk("abort_rd_stop", n_rd - r0, 0);
    chk("abort_done", n_done, 0);
    chk("abort_last", n_last, 0);
    chk("abort_frame_cnt", int'(frame_cnt), exp_frames);
    chk("abort_drop_cnt", int'(drop_cnt), exp_drops);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ovf_kept", int'(len_ovf), 1);
    exp_q.delete();
    clr();
    en = 1'b1;
    repeat (12) cyc();
    chk("reflush_cycles", n_frst, 4);
    chk("reflush_ovf", int'(len_ovf), 0);
    chk("reflush_busy", int'(busy), 0);
    chk("reflush_reads", n_rd, 0);

    // Reset in the middle of a frame
    clr();
    push_words(10, 1'b1);
    strobe(16'd80);
    wait_rd(2, 20);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_wr_en", int'(d_wr_en), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_frame_cnt", int'(frame_cnt), 0);
    chk("midrst_drop_cnt", int'(drop_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/earth_rx_drain.md
Name: earth_rx_drain

Overview:
- Ethernet receive-side drain engine: the counterpart of the TX feeder. It pulls 64-bit words out of the Ethernet RX FIFO one frame at a time and writes them into a downstream user FIFO.
- Frame size comes from a per-frame byte-length strobe supplied alongside the RX FIFO. The block flushes the RX FIFO on each enable, delimits frames with a last flag and a final-word byte count, discards oversize frames, and keeps frame and drop counters.

Parameters:
- MAX_LEN, 1500, largest accepted payload in bytes; longer frames are read out and discarded.
- FLUSH_CYC, 4, number of cycles erx_fifo_rst is held high at the start of a flush.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous to clk, active-high
- en  in  1  block enable; 0 aborts activity and idles
- erx_empty  in  1  RX FIFO empty
- erx_rd_en  out  1  RX FIFO read strobe; data returns one cycle later
- erx_dout  in  64  RX FIFO read data
- erx_len_valid  in  1  one-cycle strobe: frame length available
- erx_data_length  in  16  frame payload length in bytes, qualified by erx_len_valid
- erx_fifo_rst  out  1  RX FIFO reset/flush
- d_afull  in  1  downstream FIFO has at most 1 free slot
- d_wr_en  out  1  downstream write strobe
- d_din  out  64  downstream data; combinational pass-through of erx_dout
- d_last  out  1  qualifies d_wr_en; final word of the frame
- d_last_bytes  out  4  valid bytes in the final word (1..8); 0 when d_last=0
- frame_done  out  1  one-cycle pulse when a frame finishes, written or dropped
- frame_cnt  out  16  frames written downstream, wraps at 65535 to 0
- drop_cnt  out  16  oversize frames discarded, wraps
- len_ovf  out  1  sticky: a length strobe was lost
- busy  out  1  state is not IDLE and not WAIT_LEN

Behaviour:
- Reset values: every output 0 and state IDLE. The pending-length slot is cleared, the counters are 0 and len_ovf is 0. rst overrides every other input on the same edge.
- States:
  - IDLE: all strobes 0. On en=1, go to FLUSH.
  - FLUSH: erx_fifo_rst=1 for exactly FLUSH_CYC cycles, then go to WAIT_EMPTY. The pending slot is cleared and length strobes are ignored.
  - WAIT_EMPTY: erx_fifo_rst=0. Go to WAIT_LEN once erx_empty=1. If FIFO not yet empty, re-enter FLUSH instead.
  - WAIT_LEN: on pending-length valid, consume it and compute:
    - words = (len+7)>>3, evaluated in 17 bits and held in a 14-bit counter (max 8192).
    - lastb = len[2:0], or 8 if len[2:0]=0.
    - len=0: discard, no counters change, stay in WAIT_LEN.
    - len>MAX_LEN: go to DISCARD.
    - otherwise: go to DRAIN.
  - DRAIN: erx_rd_en=1 in every cycle where erx_empty=0, d_afull=0 and words_left>0. words_left is decremented on each read.
  - DISCARD: same read rule, but d_afull is ignored and d_wr_en stays 0.
  - Both DRAIN and DISCARD go to WAIT_LEN the cycle after the last read is issued, with frame_done=1 in that cycle.
- Read-to-write latency:
  - d_wr_en(t+1) = erx_rd_en(t) in DRAIN.
  - d_last(t+1)=1 only for the read that brought words_left to 0; d_last_bytes=lastb in that cycle.
  - The d_afull rule guarantees the one in-flight word always fits.
- Counters: frame_cnt increments with the frame_done of a DRAIN frame; drop_cnt increments with the frame_done of a DISCARD frame.
- Length capture:
  - One-deep pending slot, loaded by erx_len_valid in any state except IDLE and FLUSH.
  - A strobe arriving while the slot is full is lost and sets len_ovf. len_ovf is cleared only by rst or by entering FLUSH.
  - Load and consume in the same cycle is legal: the new length occupies the slot.
- en=0 in any state: next cycle is IDLE and erx_rd_en=0.
  - The in-flight word, if any, is still written with d_last=0.
  - The partial frame does not count toward frame_cnt or drop_cnt and produces no frame_done.
  - Re-enabling always flushes.
- rst mid-frame: immediate return to IDLE; no in-flight write.

Test Plan:
- rst=0, en=1, erx_empty=1 -> erx_fifo_rst high exactly 4 cycles, then WAIT_LEN, busy=0, no reads.
- Length 20, 3 words queued, d_afull=0 -> 3 consecutive reads; d_wr_en 1 cycle later each; third word has d_last=1, d_last_bytes=4; frame_done once; frame_cnt=1.
- Length 64, d_afull pulsed high for 5 cycles after the 2nd read -> reads pause, exactly 8 writes total, d_last_bytes=8, no lost or duplicated data (compare against an incrementing pattern).
- Length 1600 (>MAX_LEN) -> 200 reads, zero d_wr_en, drop_cnt=1, frame_cnt unchanged. Then length 8 -> 1 write, d_last_bytes=8.
- Three length strobes back-to-back during a 100-word DRAIN -> second held, third lost, len_ovf=1. Frames 1 and 2 completed, frame_cnt=2.
- en dropped after 3 of 10 words, then re-raised -> erx_rd_en stops next cycle, no frame_done, counters unchanged, FLUSH repeats with erx_fifo_rst high 4 cycles, len_ovf cleared.
